// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline stage registers: control-bit indices
// and the occupancy state used by the skid-buffered stage register.
package arm_pipe_pkg;

    localparam int CTRL_WB_EN  = 0;
    localparam int CTRL_MEM_R  = 1;
    localparam int CTRL_MEM_W  = 2;
    localparam int PIPE_CTRL_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus ctrl/dest/alu/val_rm payload.
// Clear wins over load, so a squashed entry never becomes valid.
module pipe_slot
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DEST_W-1:0] d_dest,
    input  logic [DATA_W-1:0] d_alu,
    input  logic [DATA_W-1:0] d_val_rm,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DEST_W-1:0] dest,
    output logic [DATA_W-1:0] alu,
    output logic [DATA_W-1:0] val_rm
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            ctrl   <= '0;
            dest   <= '0;
            alu    <= '0;
            val_rm <= '0;
        end else begin
            if (clear)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            if (load && !clear) begin
                ctrl   <= d_ctrl;
                dest   <= d_dest;
                alu    <= d_alu;
                val_rm <= d_val_rm;
            end
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM stage register with valid/ready handshake, optional skid entry,
// synchronous flush and masking of control bits on empty slots.
module exe_mem_pipe_reg
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEST_W  = 4,
    parameter int CTRL_W  = PIPE_CTRL_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_val_rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_val_rm
);

    logic              accept;
    logic              fire;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DEST_W-1:0] main_d_dest;
    logic [DATA_W-1:0] main_d_alu;
    logic [DATA_W-1:0] main_d_val_rm;
    logic [CTRL_W-1:0] main_ctrl;

    assign accept     = in_valid & in_ready;
    assign fire       = out_valid & out_ready;
    assign main_clear = flush | (fire & ~main_load);

    pipe_slot #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .clear    (main_clear),
        .d_ctrl   (main_d_ctrl),
        .d_dest   (main_d_dest),
        .d_alu    (main_d_alu),
        .d_val_rm (main_d_val_rm),
        .valid    (out_valid),
        .ctrl     (main_ctrl),
        .dest     (out_dest),
        .alu      (out_alu),
        .val_rm   (out_val_rm)
    );

    // An empty or squashed slot must never write memory or the register file
    assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

    generate
        if (SKID_EN) begin : g_skid
            occ_state_t        state;
            occ_state_t        next_state;
            logic              ready_q;
            logic              skid_load;
            logic              skid_clear;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DEST_W-1:0] skid_dest;
            logic [DATA_W-1:0] skid_alu;
            logic [DATA_W-1:0] skid_val_rm;

            assign in_ready   = ready_q;
            assign skid_load  = (state == ONE) & accept & ~fire;
            assign skid_clear = flush | (skid_valid & fire);
            assign main_load  = ((state == EMPTY) & accept)
                              | ((state == ONE) & accept & fire)
                              | ((state == FULL) & fire);

            // The skid entry only refills main, so FIFO order is preserved
            assign main_d_ctrl   = skid_valid ? skid_ctrl   : in_ctrl;
            assign main_d_dest   = skid_valid ? skid_dest   : in_dest;
            assign main_d_alu    = skid_valid ? skid_alu    : in_alu;
            assign main_d_val_rm = skid_valid ? skid_val_rm : in_val_rm;

            always_comb begin
                next_state = state;
                case (state)
                    EMPTY:   if (accept) next_state = ONE;
                    ONE: begin
                        if (accept && !fire)
                            next_state = FULL;
                        else if (!accept && fire)
                            next_state = EMPTY;
                    end
                    FULL:    if (fire) next_state = ONE;
                    default: next_state = EMPTY;
                endcase
                if (flush)
                    next_state = EMPTY;
            end

            // in_ready is registered so EXE never sees a combinational path from MEM
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state   <= next_state;
                    ready_q <= (next_state != FULL);
                end
            end

            pipe_slot #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_skid (
                .clk      (clk),
                .rst      (rst),
                .load     (skid_load),
                .clear    (skid_clear),
                .d_ctrl   (in_ctrl),
                .d_dest   (in_dest),
                .d_alu    (in_alu),
                .d_val_rm (in_val_rm),
                .valid    (skid_valid),
                .ctrl     (skid_ctrl),
                .dest     (skid_dest),
                .alu      (skid_alu),
                .val_rm   (skid_val_rm)
            );
        end else begin : g_single
            assign in_ready      = out_ready | ~out_valid;
            assign main_load     = accept;
            assign main_d_ctrl   = in_ctrl;
            assign main_d_dest   = in_dest;
            assign main_d_alu    = in_alu;
            assign main_d_val_rm = in_val_rm;
        end
    endgenerate

endmodule
